// File: rtl/cpu16_pkg.sv
// cpu16_pkg: shared datapath types and encodings for the 16-bit CPU blocks.
package cpu16_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PASS = 2'b01,
        ST_FAIL = 2'b10
    } status_t;

    // Adder response bundle, packed as {V, Co, S}
    typedef struct packed {
        logic              v;
        logic              co;
        logic [WORD_W-1:0] s;
    } result_t;

endpackage

// File: rtl/adder_ref_model.sv
// adder_ref_model: behavioural sum/carry/overflow reference, independent of the ripple adder.
module adder_ref_model
    import cpu16_pkg::*;
(
    input  logic [WORD_W-1:0] i_a,
    input  logic [WORD_W-1:0] i_b,
    input  logic              i_cin,
    output result_t           o_exp
);

    logic [WORD_W:0] w_sum;

    assign w_sum = {1'b0, i_a} + {1'b0, i_b} + {{WORD_W{1'b0}}, i_cin};
    // Signed overflow: like-signed operands producing an opposite-signed sum
    assign o_exp = {(i_a[WORD_W-1] == i_b[WORD_W-1]) && (w_sum[WORD_W-1] != i_a[WORD_W-1]), w_sum};

endmodule

// File: rtl/adder_result_checker.sv
// adder_result_checker: two-stage on-chip checker comparing adder responses against a reference,
// with vector/error counters, first-fail capture and a sticky pass/fail status.
module adder_result_checker
    import cpu16_pkg::*;
#(
    parameter int ERR_W   = 16,
    parameter bit CHECK_V = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] A,
    input  logic [WORD_W-1:0] B,
    input  logic              Cin,
    input  logic [WORD_W-1:0] S,
    input  logic              Co,
    input  logic              V,
    output logic              chk_valid,
    output logic              chk_err,
    output logic [31:0]       vec_count,
    output logic [ERR_W-1:0]  err_count,
    output logic [1:0]        status,
    output logic [WORD_W-1:0] ff_a,
    output logic [WORD_W-1:0] ff_b,
    output logic              ff_cin,
    output logic [17:0]       ff_got,
    output logic [17:0]       ff_exp
);

    logic              r_v1;
    logic [WORD_W-1:0] r_a;
    logic [WORD_W-1:0] r_b;
    logic              r_cin;
    result_t           r_got;
    status_t           r_state;
    result_t           w_exp;
    logic              w_mis;

    adder_ref_model u_ref (
        .i_a   (r_a),
        .i_b   (r_b),
        .i_cin (r_cin),
        .o_exp (w_exp)
    );

    assign w_mis  = (r_got.s != w_exp.s) || (r_got.co != w_exp.co) || (CHECK_V && (r_got.v != w_exp.v));
    assign status = r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1  <= 1'b0;
            r_a   <= '0;
            r_b   <= '0;
            r_cin <= 1'b0;
            r_got <= '0;
        end else if (clear) begin
            r_v1 <= 1'b0;
        end else begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_a   <= A;
                r_b   <= B;
                r_cin <= Cin;
                r_got <= {V, Co, S};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk_valid <= 1'b0;
            chk_err   <= 1'b0;
            vec_count <= '0;
            err_count <= '0;
            ff_a      <= '0;
            ff_b      <= '0;
            ff_cin    <= 1'b0;
            ff_got    <= '0;
            ff_exp    <= '0;
            r_state   <= ST_IDLE;
        end else if (clear) begin
            chk_valid <= 1'b0;
            chk_err   <= 1'b0;
            vec_count <= '0;
            err_count <= '0;
            ff_a      <= '0;
            ff_b      <= '0;
            ff_cin    <= 1'b0;
            ff_got    <= '0;
            ff_exp    <= '0;
            r_state   <= ST_IDLE;
        end else begin
            chk_valid <= r_v1;
            chk_err   <= r_v1 && w_mis;
            if (r_v1) begin
                vec_count <= vec_count + 32'd1;
                if (w_mis && err_count != '1)
                    err_count <= err_count + 1'b1;
                // Only the first failure since clear/reset is captured
                if (w_mis && r_state != ST_FAIL) begin
                    ff_a   <= r_a;
                    ff_b   <= r_b;
                    ff_cin <= r_cin;
                    ff_got <= r_got;
                    ff_exp <= w_exp;
                end
                r_state <= w_mis ? ST_FAIL : (r_state == ST_IDLE ? ST_PASS : r_state);
            end
        end
    end

endmodule

// File: doc/adder_result_checker.md
# adder_result_checker

Pipelined hardware response checker for the 16-bit ripple adder. It samples one operand/result vector per clock, recomputes the expected sum, carry and signed overflow, and compares them with what the adder actually produced. It keeps vector and error counters, latches the first failing vector, and reports a pass/fail status. It sits beside the adder in the CPU datapath as an on-chip self-check; a stimulus source or the ALU issue logic drives it.

## Interface

Parameters:
- ERR_W, 16: width of the error counter, which saturates.
- CHECK_V, 1: when 1, V takes part in the comparison; when 0, V is ignored.

Ports:
- clk  in  1: the single clock. All state updates on the rising edge.
- rst  in  1: reset. Asynchronous and active-high.
- clear  in  1: synchronous clear of counters, first-fail capture, status and pipeline.
- in_valid  in  1: the current cycle carries a vector to check.
- A  in  16: operand A presented to the adder.
- B  in  16: operand B presented to the adder.
- Cin  in  1: carry-in presented to the adder.
- S  in  16: sum the adder produced.
- Co  in  1: carry-out the adder produced.
- V  in  1: signed-overflow flag the adder produced.
- chk_valid  out  1: one-cycle pulse marking that a check result is available.
- chk_err  out  1: mismatch flag. Qualified by chk_valid.
- vec_count  out  32: number of vectors checked since reset or clear. Wraps.
- err_count  out  ERR_W: number of mismatches. Saturates at all-ones.
- status  out  2: 00 IDLE, 01 PASS, 10 FAIL.
- ff_a, ff_b  out  16 each: operands of the first failing vector.
- ff_cin  out  1: carry-in of the first failing vector.
- ff_got  out  18: {V, Co, S} the adder produced for the first failing vector.
- ff_exp  out  18: {V, Co, S} expected for the first failing vector.

## Operation

- **Stage 1 (capture).** When in_valid=1, register A, B, Cin, S, Co, V together with a stage valid bit.
- **Expected values.**
  - {exp_Co, exp_S} = A + B + Cin, computed as a 17-bit unsigned sum.
  - exp_V = (A[15] == B[15]) && (exp_S[15] != A[15]).
- **Stage 2 (compare).**
  - mismatch = (S != exp_S) || (Co != exp_Co) || (CHECK_V && V != exp_V).
  - Register the result into chk_valid and chk_err.
  - Increment vec_count.
  - If mismatch, increment err_count; it holds at all-ones once saturated.
- **First-fail capture.**
  - Loads only on a mismatch while status is not FAIL, i.e. it records the first failure only.
  - Holds its value until the next clear or reset.
  - With CHECK_V=0, ff_exp[17] still records exp_V.
- **Status FSM.** Updates on the same edge as the counters.
  - IDLE to PASS: first checked vector with no mismatch.
  - IDLE to FAIL, or PASS to FAIL: any mismatch.
  - FAIL is sticky; it exits only via clear or rst.
- **clear=1.** Takes priority over everything else.
  - Zeroes the counters, first-fail registers and pipeline valid bits.
  - Sets status to IDLE.
  - A vector presented in the same cycle as clear is discarded.
  - Vectors already in flight are flushed, and no chk_valid is produced for them.
- **Back-to-back.** in_valid may stay high every cycle; throughput is one vector per clock with no stalls.

## Timing

- **Reset.** rst asynchronously forces every output to 0 (status = IDLE) and clears both pipeline valid bits.
- **Latency.**
  - A vector sampled at edge N produces chk_valid=1 in the cycle following edge N+1.
  - At that same edge N+1, the counters, status and first-fail registers take their new values.
- **chk_valid.** High for exactly one cycle per accepted vector; chk_err is 0 whenever chk_valid is 0.
- **vec_count wrap.** 0xFFFFFFFF plus one vector gives 0x00000000. Status and err_count are unaffected by the wrap.
- **err_count saturation.** Saturation does not change status or the first-fail capture.
- **rst mid-stream.** Discards in-flight vectors; the first valid after rst deasserts is checked normally.

## Structure

- **Shared package (cpu16_pkg).**
  - Status encodings ST_IDLE, ST_PASS, ST_FAIL.
  - Typedef for the 18-bit {V, Co, S} result bundle.
  - WORD_W = 16.
- **Sub-module adder_ref_model.** A purely combinational reference computing exp_S, exp_Co and exp_V. It is behavioural (uses "+") and deliberately independent of the adder under check.
- **Top level.** Holds the two pipeline stages, counters, FSM and first-fail capture.

## Test plan

- **Good vector.** A=0x7530, B=0x7530, Cin=0, S=0xEA60, Co=0, V=1 → chk_valid two edges later, chk_err=0, vec_count=1, status=PASS.
- **Corrupted sum, then good vector.** Same vector with S=0xEA61, then a good vector → first gives chk_err=1, err_count=1, status=FAIL, ff_got=0x2EA61, ff_exp=0x2EA60. The following good vector leaves ff_* unchanged and status stays FAIL.
- **Carry and overflow corners, back-to-back.**
  - 0xFFFF+0x0001+0 with S=0x0000, Co=1, V=0 → chk_err=0.
  - 0x8000+0x8000+1 with S=0x0001, Co=1, V=1 → chk_err=0.
  - Then with V=0 driven: chk_err=1 if CHECK_V=1, chk_err=0 if CHECK_V=0.
- **Streaming.** 1000 consecutive valid cycles with a correct model → 1000 chk_valid pulses, vec_count=1000, err_count=0.
- **Saturation.** ERR_W=4 with 20 mismatching vectors → err_count holds at 15.
- **clear with a vector in flight.** clear asserted the cycle after a mismatching vector → no chk_valid for that vector, all counters 0, status=IDLE. Also: rst asserted mid-stream → all outputs 0 immediately.
